// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: walks a per-effect note ROM and drives freq/duty of the buzzer PWM stage.
// Optional feature macro: SFX_VOLUME_EN adds a 2-bit volume input that scales sounding duty.
module sfx_sequencer #(
  parameter int unsigned TICK_CYCLES = 1_000_000,
  parameter int unsigned IDLE_FREQ   = 1000,
  parameter int unsigned DUTY_ON     = 512
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sfx_req,
  input  logic [1:0]  sfx_id,
`ifdef SFX_VOLUME_EN
  input  logic [1:0]  volume,
`endif
  output logic [31:0] freq,
  output logic [9:0]  duty,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_t;

  state_t        state, state_nx;
  logic          req_q;
  logic [1:0]    id_q, cur_id, cur_id_nx;
  logic [2:0]    idx, idx_nx;
  logic [CW-1:0] cyc, cyc_nx;
  logic [5:0]    tick, tick_nx, dur, dur_nx;
  logic [31:0]   freq_nx;
  logic [9:0]    duty_nx, duty_snd;
  logic          busy_nx, done_nx, accept;
  logic [21:0]   rom_q;

  // Entries are {freq[15:0], dur[5:0]}; freq 0 is a rest, dur 0 ends the effect.
  function automatic logic [21:0] note_rom(input logic [1:0] id, input logic [2:0] i);
    case ({id, i})
      5'b01_000: return {16'd523,  6'd5};
      5'b01_001: return {16'd784,  6'd5};
      5'b10_000: return {16'd988,  6'd4};
      5'b10_001: return {16'd1319, 6'd12};
      5'b11_000: return {16'd392,  6'd6};
      5'b11_001: return {16'd0,    6'd3};
      5'b11_010: return {16'd330,  6'd6};
      5'b11_011: return {16'd0,    6'd3};
      5'b11_100: return {16'd262,  6'd20};
      default:   return '0;
    endcase
  endfunction

`ifdef SFX_VOLUME_EN
  assign duty_snd = (volume == 2'd0) ? '0 : 10'(DUTY_ON >> (2'd3 - volume));
`else
  assign duty_snd = 10'(DUTY_ON);
`endif

  assign rom_q  = note_rom(cur_id, idx);
  // Requests are registered first, so acceptance acts one edge after sampling.
  assign accept = req_q && (id_q != 2'd0) && ((state == S_IDLE) || (id_q > cur_id));

  always_comb begin
    state_nx  = state;
    cur_id_nx = cur_id;
    idx_nx    = idx;
    cyc_nx    = cyc;
    tick_nx   = tick;
    dur_nx    = dur;
    freq_nx   = freq;
    duty_nx   = duty;
    busy_nx   = busy;
    done_nx   = 1'b0;
    case (state)
      S_IDLE: ;
      S_LOAD: begin
        if (rom_q[5:0] == 6'd0) begin
          state_nx = S_IDLE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          freq_nx  = 32'(IDLE_FREQ);
          duty_nx  = '0;
        end else begin
          state_nx = S_PLAY;
          dur_nx   = rom_q[5:0];
          cyc_nx   = '0;
          tick_nx  = '0;
          if (rom_q[21:6] != 16'd0) begin
            freq_nx = {16'd0, rom_q[21:6]};
            duty_nx = duty_snd;
          end else begin
            duty_nx = '0;
          end
        end
      end
      S_PLAY: begin
        if (cyc == CYC_LAST) begin
          cyc_nx  = '0;
          tick_nx = tick + 6'd1;
          if (tick + 6'd1 == dur) begin
            idx_nx   = idx + 3'd1;
            state_nx = S_LOAD;
          end
        end else begin
          cyc_nx = cyc + 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    // Acceptance wins over whatever the state would have done, including end-of-table.
    if (accept) begin
      cur_id_nx = id_q;
      idx_nx    = '0;
      state_nx  = S_LOAD;
      busy_nx   = 1'b1;
      done_nx   = 1'b0;
      freq_nx   = freq;
      duty_nx   = duty;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      req_q  <= 1'b0;
      id_q   <= '0;
      cur_id <= '0;
      idx    <= '0;
      cyc    <= '0;
      tick   <= '0;
      dur    <= '0;
      freq   <= 32'(IDLE_FREQ);
      duty   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      req_q  <= sfx_req;
      id_q   <= sfx_id;
      cur_id <= cur_id_nx;
      idx    <= idx_nx;
      cyc    <= cyc_nx;
      tick   <= tick_nx;
      dur    <= dur_nx;
      freq   <= freq_nx;
      duty   <= duty_nx;
      busy   <= busy_nx;
      done   <= done_nx;
    end
  end

endmodule

// File: doc/sfx_sequencer.md
# sfx_sequencer

Sound-effect sequencer sitting directly upstream of the buzzer PWM generator. On a request from the game logic it steps through a fixed note table for the chosen effect (jump, coin, game over) and drives the `freq` / `duty` inputs of the PWM stage, one note at a time, with durations timed by an internal 10 ms tick. When idle, it holds the buzzer silent with a safe non-zero frequency, so the PWM stage never divides by zero.

## Interface
- `TICK_CYCLES`, 1_000_000, clock cycles per duration tick (10 ms at 100 MHz); bench shrinks it.
- `IDLE_FREQ`, 1000, frequency (Hz) driven while idle; must be non-zero.
- `DUTY_ON`, 512, duty (of 1024) for sounding notes.
- `clk` in 1: system clock, 100 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `sfx_req` in 1: request strobe; sampled every rising edge.
- `sfx_id` in 2: effect. 0 = none (ignored), 1 = jump, 2 = coin, 3 = game over.
- `freq` out 32: note frequency in Hz, to PWM stage.
- `duty` out 10: duty, to PWM stage.
- `busy` out 1: effect in progress.
- `done` out 1: one-cycle pulse when an effect ends naturally.
- `volume` in 2: only with `SFX_VOLUME_EN`; see Configuration.

## Operation
- Note ROM entries are {freq[15:0], dur[5:0]}. `freq` = 0 means a rest. `dur` = 0 marks end of effect. `freq` is zero-extended to 32 bits on output.
- **Jump (id 1):**
  - 523 Hz for 5 ticks
  - 784 Hz for 5 ticks
  - end
- **Coin (id 2):**
  - 988 Hz for 4 ticks
  - 1319 Hz for 12 ticks
  - end
- **Game over (id 3):**
  - 392 Hz for 6 ticks
  - rest for 3 ticks
  - 330 Hz for 6 ticks
  - rest for 3 ticks
  - 262 Hz for 20 ticks
  - end
- **States:**
  - IDLE: `busy` = 0, `duty` = 0, `freq` = `IDLE_FREQ`.
  - LOAD: reads ROM[`cur_id`, `idx`].
    - If `dur` = 0: go to IDLE, pulse `done`, `freq` = `IDLE_FREQ`, `duty` = 0.
    - Otherwise: latch the note, clear the cycle and tick counters, go to PLAY.
  - PLAY: counts cycles.
    - Every `TICK_CYCLES` cycles, the tick counter increments.
    - When the tick counter reaches `dur`: `idx`++, go to LOAD.
- **Sounding note:** `freq` = ROM freq, `duty` = `DUTY_ON`.
- **Rest:** `freq` holds its previous value, `duty` = 0.
- **Accept rule:** a request is accepted when `sfx_req`=1 and `sfx_id`≠0, and either
  - the state is IDLE, or
  - `sfx_id` > `cur_id` (preemption).
- On accept: `cur_id` ← `sfx_id`, `idx` ← 0, next state LOAD. This overrides any transition the current state would otherwise take.
- A request with the same or lower priority while busy is dropped silently.
- Preempted effects do not pulse `done`.
- **Request in the same cycle a LOAD hits end-of-table:** the request is accepted, `done` is not pulsed, and `busy` stays 1.

## Timing
- Reset values:
  - `freq` = `IDLE_FREQ`, `duty` = 0, `busy` = 0, `done` = 0
  - state IDLE, `idx` = 0, `cur_id` = 0
- Reset mid-effect aborts immediately (asynchronous); no `done` pulse.
- **Request latency:**
  - `sfx_req` sampled at edge N → `busy` = 1 and state LOAD after edge N+1.
  - First note on `freq` / `duty` after edge N+2.
- Each note occupies exactly `dur`×`TICK_CYCLES` PLAY cycles plus 1 LOAD cycle. During that LOAD cycle the outputs hold the previous note.
- **End of effect:** LOAD at edge M finds `dur` = 0. After edge M+1:
  - `busy` = 0, `duty` = 0, `freq` = `IDLE_FREQ`
  - `done` = 1 for that one cycle only
- Outputs are registered, with no combinational path from inputs.
- Cycle counter width is ≥ clog2(`TICK_CYCLES`). Tick counter is 6 bits.

## Configuration
- `SFX_VOLUME_EN`:
  - **Defined:** adds the `volume` input, sampled at each LOAD. Sounding-note duty is `DUTY_ON` >> (3−`volume`) for `volume` 1..3. `volume` = 0 gives duty 0 (mute) while timing and `busy` / `done` behave unchanged.
  - **Undefined:** no `volume` port; sounding duty is always `DUTY_ON`.

## Test plan
- **Reset:** `reset_n`=0 mid-PLAY of id 3 → `freq`=1000, `duty`=0, `busy`=0 immediately. After release, `done` never pulses.
- **Jump** (`TICK_CYCLES`=4), req id 1 at edge 0:
  - `busy`=1 after edge 1.
  - `freq`=523, `duty`=512 after edge 2, for 21 cycles.
  - `freq`=784 for 21 cycles.
  - `done`=1 for exactly one cycle, then `busy`=0, `freq`=1000.
- **Game over rests:** during each rest `duty`=0 and `freq` holds 392 then 330. The 262 Hz note lasts 81 cycles.
- **Preemption:** id 1 playing, req id 3 → `cur_id`=3, `freq`=392 two cycles later, and no `done` pulse for the jump. Req id 2 during id 3 → ignored.
- **Simultaneous end and request:** req id 2 on the terminating LOAD cycle of id 1 → `busy` stays 1, no `done`, `freq`=988 two cycles later.
- **`SFX_VOLUME_EN`:**
  - `volume`=1 → `duty`=128.
  - `volume`=0 → `duty`=0, but `done` still arrives on schedule.
